div_job_scheduler: RTL and testbench

- Shares one fixed_divider instance between NUM_REQ requesters, each streaming a 4096-bit dividend as NUM_BLOCKS_IN blocks, LSB block first.
- Grants requesters round-robin and feeds the granted frame to the divider contiguously.
- Forwards the NUM_BLOCKS_OUT quotient blocks tagged with the requester id.
- Inserts a guard gap between jobs so the divider's internal multiplier clears before the next frame.

---
 rtl/div_job_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_div_job_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_job_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one fixed_divider between NUM_REQ dividend streams.
// Define DIV_JOB_SCHEDULER_TIMEOUT_EN to add the DRAIN watchdog and the timeout_out port.
module div_job_scheduler #(
    parameter int REGISTER_SIZE  = 32,
    parameter int NUM_BLOCKS_IN  = 128,
    parameter int NUM_BLOCKS_OUT = 64,
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0] req_block_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic                             div_valid_out,
    output logic [REGISTER_SIZE-1:0]         div_block_out,
    input  logic                             div_valid_in,
    input  logic [REGISTER_SIZE-1:0]         div_block_in,
    output logic                             result_valid_out,
    output logic [REGISTER_SIZE-1:0]         result_block_out,
    output logic [$clog2(NUM_REQ)-1:0]       result_id_out,
    output logic                             busy_out,
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
    output logic                             timeout_out,
`endif
    output logic                             protocol_err_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IN_W  = $clog2(NUM_BLOCKS_IN + 1);
    localparam int OUT_W = $clog2(NUM_BLOCKS_OUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, GAP} state_t;

    state_t             state, state_next;
    logic [ID_W-1:0]    grant, grant_next, ptr, ptr_next, pick;
    logic               pick_found;
    logic               granted_valid;
    logic [REGISTER_SIZE-1:0] granted_block;
    logic [IN_W-1:0]    in_cnt, in_cnt_next;
    logic [OUT_W-1:0]   out_cnt, out_cnt_next;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
    logic               drain_done;
    logic               div_valid_next;
    logic [REGISTER_SIZE-1:0] div_block_next;
    logic               result_valid_next;
    logic [REGISTER_SIZE-1:0] result_block_next;
    logic [ID_W-1:0]    result_id_next;
    logic               err_next;

`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_cnt, wd_cnt_next;
    logic               timeout_next;
`else
    // Parameter stays declared so named overrides remain legal without the watchdog.
    logic               timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
`endif

    assign busy_out = (state != IDLE);

    // Cyclic search for the first valid requester at or after the pointer.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        pick          = '0;
        pick_found    = 1'b0;
        granted_block = '0;
        granted_valid = req_valid_in[grant];
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && req_valid_in[ID_W'(idx)]) begin
                pick       = ID_W'(idx);
                pick_found = 1'b1;
            end
        end
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == grant) granted_block = req_block_in[r*REGISTER_SIZE +: REGISTER_SIZE];
        end
    end

    always_comb begin
        state_next        = state;
        grant_next        = grant;
        ptr_next          = ptr;
        in_cnt_next       = in_cnt;
        out_cnt_next      = out_cnt;
        gap_cnt_next      = gap_cnt;
        drain_done        = 1'b0;
        req_ready_out     = '0;
        div_valid_next    = 1'b0;
        div_block_next    = '0;
        result_valid_next = 1'b0;
        result_block_next = result_block_out;
        result_id_next    = result_id_out;
        err_next          = protocol_err_out;
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
        wd_cnt_next       = wd_cnt;
        timeout_next      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next  = pick;
                    in_cnt_next = '0;
                    state_next  = FEED;
                end
            end
            FEED: begin
                // Missing beats are zero-filled so the divider always sees a full frame.
                req_ready_out[grant] = 1'b1;
                div_valid_next       = 1'b1;
                if (granted_valid) div_block_next = granted_block;
                else               err_next       = 1'b1;
                if (in_cnt == IN_W'(NUM_BLOCKS_IN - 1)) begin
                    in_cnt_next  = '0;
                    out_cnt_next = '0;
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
                    wd_cnt_next  = '0;
`endif
                    state_next   = DRAIN;
                end else begin
                    in_cnt_next = in_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (div_valid_in) begin
                    result_valid_next = 1'b1;
                    result_block_next = div_block_in;
                    result_id_next    = grant;
                    if (out_cnt == OUT_W'(NUM_BLOCKS_OUT - 1)) drain_done   = 1'b1;
                    else                                      out_cnt_next = out_cnt + 1'b1;
                end
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
                wd_cnt_next = wd_cnt + 1'b1;
                if (!drain_done && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_next = 1'b1;
                    err_next     = 1'b1;
                    drain_done   = 1'b1;
                end
`endif
                if (drain_done) begin
                    out_cnt_next = '0;
                    gap_cnt_next = '0;
                    ptr_next     = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (div_valid_in && state != DRAIN) err_next = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            grant            <= '0;
            ptr              <= '0;
            in_cnt           <= '0;
            out_cnt          <= '0;
            gap_cnt          <= '0;
            div_valid_out    <= 1'b0;
            div_block_out    <= '0;
            result_valid_out <= 1'b0;
            result_block_out <= '0;
            result_id_out    <= '0;
            protocol_err_out <= 1'b0;
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
            wd_cnt           <= '0;
            timeout_out      <= 1'b0;
`endif
        end else begin
            state            <= state_next;
            grant            <= grant_next;
            ptr              <= ptr_next;
            in_cnt           <= in_cnt_next;
            out_cnt          <= out_cnt_next;
            gap_cnt          <= gap_cnt_next;
            div_valid_out    <= div_valid_next;
            div_block_out    <= div_block_next;
            result_valid_out <= result_valid_next;
            result_block_out <= result_block_next;
            result_id_out    <= result_id_next;
            protocol_err_out <= err_next;
`ifdef DIV_JOB_SCHEDULER_TIMEOUT_EN
            wd_cnt           <= wd_cnt_next;
            timeout_out      <= timeout_next;
`endif
        end
    end

endmodule

// File: tb/tb_div_job_scheduler.sv
`timescale 1ns/1ps
// Directed bench for div_job_scheduler: a table of whole jobs (arbitration, data, errors)
// plus hand-written reset-mid-frame and stray-divider-beat sequences.
module tb_div_job_scheduler;

    localparam int RS  = 32;
    localparam int NBI = 128;
    localparam int NBO = 64;
    localparam int NR  = 2;
    localparam int GAP = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR*RS-1:0]  req_block_in;
    logic [NR-1:0]     req_ready_out;
    logic              div_valid_out;
    logic [RS-1:0]     div_block_out;
    logic              div_valid_in;
    logic [RS-1:0]     div_block_in;
    logic              result_valid_out;
    logic [RS-1:0]     result_block_out;
    logic [0:0]        result_id_out;
    logic              busy_out;
    logic              protocol_err_out;

    always #5 clk_in = ~clk_in;

    div_job_scheduler #(
        .REGISTER_SIZE (RS),
        .NUM_BLOCKS_IN (NBI),
        .NUM_BLOCKS_OUT(NBO),
        .NUM_REQ       (NR),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_block_in    (req_block_in),
        .req_ready_out   (req_ready_out),
        .div_valid_out   (div_valid_out),
        .div_block_out   (div_block_out),
        .div_valid_in    (div_valid_in),
        .div_block_in    (div_block_in),
        .result_valid_out(result_valid_out),
        .result_block_out(result_block_out),
        .result_id_out   (result_id_out),
        .busy_out        (busy_out),
        .protocol_err_out(protocol_err_out)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] blk(input int r, input int k);
        return 32'hC0DE_0000 | (32'(r) << 12) | 32'(k);
    endfunction

    function automatic logic [31:0] quo(input int job, input int j);
        return 32'h5A00_0000 | (32'(job) << 8) | 32'(j);
    endfunction

    task automatic set_blocks(input int k);
        for (int r = 0; r < NR; r++) req_block_in[r*RS +: RS] = blk(r, k);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 32'({div_valid_out, result_valid_out, busy_out, protocol_err_out,
                                req_ready_out, result_id_out}), 32'd0);
        chk({name, "_data"}, div_block_out | result_block_out, 32'd0);
    endtask

    // One full job from an IDLE sample point; rst_beat >= 0 aborts with reset at that FEED beat.
    task automatic run_job(input int job, input logic [1:0] mask, input int drop,
                           input int exp_id, input logic exp_err, input int rst_beat);
        int data_bad, ready_bad, res_bad, gap_bad;
        logic [31:0] expv;
        data_bad = 0; ready_bad = 0; res_bad = 0; gap_bad = 0;

        chk("idle_before_grant", 32'(busy_out), 32'd0);
        req_valid_in = mask;
        set_blocks(0);
        @(posedge clk_in); #1;
        chk("grant_onehot", 32'(req_ready_out), 32'(1 << exp_id));

        for (int k = 0; k < NBI; k++) begin
            if (k == rst_beat) begin
                chk("feed_before_reset", 32'(data_bad + ready_bad), 32'd0);
                rst_in       = 1'b1;
                req_valid_in = '0;
                @(posedge clk_in); #1;
                rst_in = 1'b0;
                chk_all_zero("reset_mid_feed");
                return;
            end
            req_valid_in = mask;
            if (k == drop) req_valid_in[exp_id] = 1'b0;
            set_blocks(k);
            if (req_ready_out !== 2'(1 << exp_id)) ready_bad++;
            @(posedge clk_in); #1;
            expv = (k == drop) ? 32'd0 : blk(exp_id, k);
            if (div_valid_out !== 1'b1 || div_block_out !== expv) data_bad++;
            if (k == drop) chk("err_at_drop_beat", 32'(protocol_err_out), 32'd1);
        end
        req_valid_in = '0;
        chk("feed_bad_beats", 32'(data_bad), 32'd0);
        chk("feed_ready_bad", 32'(ready_bad), 32'd0);
        chk("ready_low_in_drain", 32'(req_ready_out), 32'd0);

        // Divider beats with an idle cycle before every 7th beat (j % 7 == 3).
        for (int j = 0; j < NBO; j++) begin
            if (j % 7 == 3) begin
                div_valid_in = 1'b0;
                @(posedge clk_in); #1;
                if (result_valid_out !== 1'b0 || div_valid_out !== 1'b0) res_bad++;
            end
            div_valid_in = 1'b1;
            div_block_in = quo(job, j);
            @(posedge clk_in); #1;
            if (result_valid_out !== 1'b1 || result_block_out !== quo(job, j) ||
                result_id_out !== 1'(exp_id) || div_valid_out !== 1'b0 || busy_out !== 1'b1)
                res_bad++;
        end
        div_valid_in = 1'b0;
        chk("drain_bad_beats", 32'(res_bad), 32'd0);

        for (int g = 1; g <= GAP; g++) begin
            @(posedge clk_in); #1;
            if (busy_out !== (g < GAP)) gap_bad++;
            if (div_valid_out !== 1'b0 || result_valid_out !== 1'b0 || req_ready_out !== '0) gap_bad++;
        end
        chk("gap_then_idle", 32'(gap_bad), 32'd0);
        chk("protocol_err", 32'(protocol_err_out), 32'(exp_err));
    endtask

    typedef struct {
        logic [1:0] mask;
        int         drop;
        int         exp_id;
        logic       exp_err;
    } job_t;

    job_t jobs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pointer walk: 0->1->0->1->0, single-requester cases, then drop on requester 1.
        jobs[0] = '{2'b11, -1, 0, 1'b0};
        jobs[1] = '{2'b11, -1, 1, 1'b0};
        jobs[2] = '{2'b11, -1, 0, 1'b0};
        jobs[3] = '{2'b11, -1, 1, 1'b0};
        jobs[4] = '{2'b01, -1, 0, 1'b0};
        jobs[5] = '{2'b01, -1, 0, 1'b0};
        jobs[6] = '{2'b10, 50, 1, 1'b1};
        jobs[7] = '{2'b11, -1, 0, 1'b1};

        rst_in       = 1'b1;
        req_valid_in = '0;
        req_block_in = '0;
        div_valid_in = 1'b0;
        div_block_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_all_zero("reset_state");
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("no_grant_without_valid", 32'({busy_out, req_ready_out}), 32'd0);

        for (int i = 0; i < 8; i++)
            run_job(i, jobs[i].mask, jobs[i].drop, jobs[i].exp_id, jobs[i].exp_err, -1);

        // Pointer is 1 here, so both valid grants requester 1; reset at beat 70 must return it to 0.
        run_job(8, 2'b11, -1, 1, 1'b0, 70);
        run_job(9, 2'b11, -1, 0, 1'b0, -1);

        div_valid_in = 1'b1;
        div_block_in = 32'hDEAD_BEEF;
        @(posedge clk_in); #1;
        div_valid_in = 1'b0;
        chk("stray_div_valid_sets_err", 32'(protocol_err_out), 32'd1);
        chk("stray_div_valid_no_result", 32'({result_valid_out, busy_out}), 32'd0);
        @(posedge clk_in); #1;
        chk("err_sticky", 32'(protocol_err_out), 32'd1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("err_cleared_by_reset", 32'(protocol_err_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
